// File: rtl/nanov_seq.sv
// nanov_seq: bit/digit-serial instruction sequencer with a two-deep
// instruction buffer (CUR + lookahead NXT) and result deserialiser.
module nanov_seq #(
  parameter int XLEN    = 32,
  parameter int DW      = 1,
  parameter int NCYCLES = 4,
  localparam int DIGITS = XLEN / DW,
  localparam int CW     = $clog2(DIGITS)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] instr,
  output logic            instr_ready,
  input  logic            stall,
  input  logic [DW-1:0]   serial_in,
  input  logic            branch_in,
  output logic [CW-1:0]   counter,
  output logic [2:0]      cycle,
  output logic [XLEN-1:0] core_instr,
  output logic [XLEN-1:0] core_next_instr,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic            result_branch,
  output logic            busy
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam logic [CW-1:0] LAST_DIG = CW'(DIGITS - 1);
  localparam logic [2:0]    LAST_CYC = 3'(NCYCLES - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_cyc;
  logic [XLEN-1:0] r_cur;
  logic [XLEN-1:0] r_nxt;
  logic            r_nxt_full;
  logic [XLEN-1:0] r_shreg;
  logic [XLEN-1:0] r_result;
  logic            r_valid;
  logic            r_branch;

  logic            w_acc;
  logic            w_last_dig;
  logic            w_last_cyc;
  logic            w_done;
  logic [XLEN-1:0] w_shnext;

  assign w_acc      = instr_valid & ~r_nxt_full;
  assign w_last_dig = (r_cnt == LAST_DIG);
  assign w_last_cyc = (r_cyc == LAST_CYC);
  assign w_done     = (r_state == S_RUN) & ~stall
                    & w_last_dig & w_last_cyc;
  assign w_shnext   = {serial_in, r_shreg[XLEN-1:DW]};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cyc      <= '0;
      r_cur      <= '0;
      r_nxt      <= '0;
      r_nxt_full <= 1'b0;
      r_shreg    <= '0;
      r_result   <= '0;
      r_valid    <= 1'b0;
      r_branch   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_cur   <= instr;
            r_cnt   <= '0;
            r_cyc   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (w_last_cyc) r_shreg <= w_shnext;
            if (w_last_dig) begin
              r_cnt <= '0;
              r_cyc <= r_cyc + 3'd1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          if (w_done) begin
            r_result <= w_shnext;
            r_valid  <= 1'b1;
            r_branch <= branch_in;
            r_cnt    <= '0;
            r_cyc    <= '0;
            // Lookahead wins; otherwise a same-edge offer goes straight to CUR
            if (r_nxt_full) begin
              r_cur      <= r_nxt;
              r_nxt      <= '0;
              r_nxt_full <= 1'b0;
            end else if (w_acc) begin
              r_cur <= instr;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_acc) begin
            r_nxt      <= instr;
            r_nxt_full <= 1'b1;
          end
        end
      endcase
    end
  end

  assign instr_ready     = ~r_nxt_full;
  assign counter         = r_cnt;
  assign cycle           = r_cyc;
  assign core_instr      = r_cur;
  assign core_next_instr = r_nxt;
  assign result          = r_result;
  assign result_valid    = r_valid;
  assign result_branch   = r_branch;
  assign busy            = (r_state == S_RUN);

endmodule

// File: tb/tb_nanov_seq.sv
// Self-checking bench for nanov_seq: directed vector tables, multi-cycle
// corner sequences and a randomized run against a reference model.
module tb_nanov_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, iv, stl, sin, br;
  logic [31:0] ins;
  logic        rdy, rv, rb, bsy;
  logic [4:0]  cnt;
  logic [2:0]  cyc;
  logic [31:0] ci, cn, res;

  logic        b_rstn, b_iv, b_stl, b_br;
  logic [3:0]  b_sin;
  logic [31:0] b_ins;
  logic        b_rdy, b_rv, b_rb, b_bsy;
  logic [2:0]  b_cnt, b_cyc;
  logic [31:0] b_ci, b_cn, b_res;

  nanov_seq #(.XLEN(32), .DW(1), .NCYCLES(4)) dut_a (
    .clk(clk), .rstn(rstn), .instr_valid(iv), .instr(ins),
    .instr_ready(rdy), .stall(stl), .serial_in(sin),
    .branch_in(br), .counter(cnt), .cycle(cyc),
    .core_instr(ci), .core_next_instr(cn), .result(res),
    .result_valid(rv), .result_branch(rb), .busy(bsy)
  );

  nanov_seq #(.XLEN(32), .DW(4), .NCYCLES(2)) dut_b (
    .clk(clk), .rstn(b_rstn), .instr_valid(b_iv), .instr(b_ins),
    .instr_ready(b_rdy), .stall(b_stl), .serial_in(b_sin),
    .branch_in(b_br), .counter(b_cnt), .cycle(b_cyc),
    .core_instr(b_ci), .core_next_instr(b_cn), .result(b_res),
    .result_valid(b_rv), .result_branch(b_rb), .busy(b_bsy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: elapsed clocks as one integer, result digits
  // placed by position rather than shifted.
  localparam int DIG = 32, TOT = 128, BASE = 96;
  bit          m_busy, m_full, m_rv, m_rb;
  int          m_k;
  logic [31:0] m_cur, m_nxt, m_res, m_acc;

  task automatic model_step();
    bit acc, done;
    if (!rstn) begin
      m_busy = 0; m_full = 0; m_rv = 0; m_rb = 0; m_k = 0;
      m_cur = 0; m_nxt = 0; m_res = 0;
      return;
    end
    m_rv = 0;
    acc = iv && !m_full;
    if (!m_busy) begin
      if (acc) begin m_cur = ins; m_k = 0; m_busy = 1; end
    end else begin
      done = !stl && (m_k == TOT - 1);
      if (!stl && m_k >= BASE) m_acc[m_k - BASE] = sin;
      if (!stl) m_k++;
      if (done) begin
        m_res = m_acc; m_rv = 1; m_rb = br; m_k = 0;
        if (m_full) begin m_cur = m_nxt; m_nxt = 0; m_full = 0; end
        else if (acc) m_cur = ins;
        else m_busy = 0;
      end else if (acc) begin
        m_nxt = ins; m_full = 1;
      end
    end
  endtask

  typedef struct {
    int         n;
    logic       busy;
    logic       rv;
    logic [4:0] cnt;
    logic [2:0] cyc;
  } vec_t;

  vec_t tbl[8];
  logic [31:0] w, bw;
  logic [31:0] wq[4];
  int pulses, ptimes[3], idx;
  bit a;

  initial begin
    tbl[0] = '{0,   1'b1, 1'b0, 5'd0,  3'd0};
    tbl[1] = '{1,   1'b1, 1'b0, 5'd1,  3'd0};
    tbl[2] = '{31,  1'b1, 1'b0, 5'd31, 3'd0};
    tbl[3] = '{32,  1'b1, 1'b0, 5'd0,  3'd1};
    tbl[4] = '{96,  1'b1, 1'b0, 5'd0,  3'd3};
    tbl[5] = '{127, 1'b1, 1'b0, 5'd31, 3'd3};
    tbl[6] = '{128, 1'b0, 1'b1, 5'd0,  3'd0};
    tbl[7] = '{129, 1'b0, 1'b0, 5'd0,  3'd0};
    w  = 32'hDEADBEEF;
    bw = 32'h12345678;

    // Reset with an offer pending: nothing may be accepted
    rstn = 0; iv = 1; ins = 32'h1111_2222; stl = 0; sin = 0; br = 0;
    b_rstn = 0; b_iv = 1; b_ins = 32'h3; b_stl = 0; b_sin = 0; b_br = 0;
    tick(); tick();
    chk("rst_ready", rdy, 1); chk("rst_busy", bsy, 0);
    chk("rst_cnt", cnt, 0);   chk("rst_cyc", cyc, 0);
    chk("rst_ci", ci, 0);     chk("rst_cn", cn, 0);
    chk("rst_res", res, 0);   chk("rst_rv", rv, 0);
    chk("rst_rb", rb, 0);
    rstn = 1; iv = 0; b_rstn = 1; b_iv = 0;
    tick();
    chk("post_rst_idle", bsy, 0);

    // DW=4, NCYCLES=2 instance
    b_ins = 32'h0000_0B0B; b_iv = 1;
    tick();
    b_iv = 0;
    for (int n = 1; n <= 17; n++) begin
      b_sin = (n >= 9 && n <= 16) ? bw[(n - 9) * 4 +: 4] : 4'd0;
      tick();
      if (n == 7)  begin chk("b_cnt7", b_cnt, 7); chk("b_cyc0", b_cyc, 0); end
      if (n == 8)  begin chk("b_wrap", b_cnt, 0); chk("b_cyc1", b_cyc, 1); end
      if (n == 15) chk("b_rv15", b_rv, 0);
      if (n == 16) begin chk("b_rv16", b_rv, 1); chk("b_res", b_res, bw); end
      if (n == 17) begin chk("b_rv17", b_rv, 0); chk("b_idle", b_bsy, 0); end
    end

    // Single instruction, timing table
    ins = 32'h00A0_0013; iv = 1;
    tick();
    iv = 0; idx = 0; pulses = 0;
    chk("single_ci", ci, 32'h00A0_0013);
    for (int n = 0; n <= 130; n++) begin
      if (n > 0) begin
        sin = (n >= 97 && n <= 128) ? w[n - 97] : 1'b0;
        br = (n == 128);
        tick();
      end
      if (rv) pulses++;
      if (idx < 8 && tbl[idx].n == n) begin
        chk($sformatf("tbl%0d_busy", n), bsy, tbl[idx].busy);
        chk($sformatf("tbl%0d_rv", n), rv, tbl[idx].rv);
        chk($sformatf("tbl%0d_cnt", n), cnt, tbl[idx].cnt);
        chk($sformatf("tbl%0d_cyc", n), cyc, tbl[idx].cyc);
        idx++;
      end
      if (n == 128) begin
        chk("single_res", res, w); chk("single_rb", rb, 1);
      end
    end
    chk("single_pulses", pulses, 1);
    chk("single_hold", res, w);
    chk("single_rb_hold", rb, 1);

    // Stall 10 clocks in cycle 2
    ins = 32'h0000_0063; iv = 1;
    tick();
    iv = 0; pulses = 0;
    for (int n = 1; n <= 140; n++) begin
      stl = (n >= 75 && n <= 84);
      sin = (n >= 107 && n <= 138) ? w[n - 107] : 1'b0;
      br = 0;
      tick();
      if (rv) pulses++;
      if (n == 80) begin
        chk("stall_cnt", cnt, 10); chk("stall_cyc", cyc, 2);
      end
      if (n == 137) chk("stall_rv137", rv, 0);
      if (n == 138) begin
        chk("stall_rv138", rv, 1); chk("stall_res", res, w);
        chk("stall_rb", rb, 0);
      end
    end
    stl = 0;
    chk("stall_pulses", pulses, 1);

    // Reset mid-instruction at counter=17, cycle=1
    ins = 32'h0000_0033; iv = 1;
    tick();
    ins = 32'h0000_0077;
    for (int n = 1; n <= 49; n++) begin
      iv = (n == 1);
      tick();
    end
    chk("mid_cnt", cnt, 17); chk("mid_cyc", cyc, 1);
    chk("mid_full", rdy, 0);
    rstn = 0;
    tick();
    rstn = 1;
    chk("mid_rst_ready", rdy, 1); chk("mid_rst_busy", bsy, 0);
    chk("mid_rst_cnt", cnt, 0);   chk("mid_rst_cyc", cyc, 0);
    chk("mid_rst_ci", ci, 0);     chk("mid_rst_cn", cn, 0);
    chk("mid_rst_res", res, 0);   chk("mid_rst_rv", rv, 0);
    pulses = 0;
    for (int n = 0; n < 140; n++) begin
      tick();
      if (rv) pulses++;
    end
    chk("mid_no_pulse", pulses, 0);
    chk("mid_idle", bsy, 0);

    // Three back-to-back instructions, valid held
    wq[0] = 32'hA1; wq[1] = 32'hB2; wq[2] = 32'hC3; wq[3] = 0;
    idx = 0; iv = 1; ins = wq[0]; pulses = 0;
    for (int n = 0; n <= 400; n++) begin
      a = iv && rdy;
      tick();
      if (a) begin
        idx++;
        ins = wq[idx];
        iv = (idx < 3);
      end
      if (rv) begin
        if (pulses < 3) ptimes[pulses] = n;
        pulses++;
      end
      if (n == 1) begin
        chk("b2b_cn", cn, wq[1]); chk("b2b_ready", rdy, 0);
      end
      if (n == 128) begin
        chk("b2b_ci", ci, wq[1]); chk("b2b_busy", bsy, 1);
      end
    end
    chk("b2b_pulses", pulses, 3);
    chk("b2b_t0", ptimes[0], 128);
    chk("b2b_t1", ptimes[1], 256);
    chk("b2b_t2", ptimes[2], 384);
    chk("b2b_end_idle", bsy, 0);

    // Randomized run against the model
    rstn = 0; iv = 0; stl = 0;
    model_step();
    tick();
    for (int t = 0; t < 1500; t++) begin
      rstn = ($urandom % 400) != 0;
      iv   = ($urandom % 3) != 0;
      ins  = $urandom;
      stl  = ($urandom % 6) == 0;
      sin  = 1'($urandom);
      br   = 1'($urandom);
      model_step();
      tick();
      chk("rnd_ready", rdy, !m_full);
      chk("rnd_busy", bsy, m_busy);
      chk("rnd_cnt", cnt, m_k % DIG);
      chk("rnd_cyc", cyc, m_k / DIG);
      chk("rnd_ci", ci, m_cur);
      chk("rnd_cn", cn, m_nxt);
      chk("rnd_rv", rv, m_rv);
      chk("rnd_rb", rb, m_rb);
      chk("rnd_res", res, m_res);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
